// File: rtl/io_input_conditioner.sv
// Board pin conditioner: 2-flop synchronizers plus per-bit debounce
// for KEY/SW pins, with registered bus and key press strobes.
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  key_raw,
  input  logic [9:0]  sw_raw,
  output logic [13:0] io_input_bus,
  output logic [3:0]  key_press
);

  localparam int NB = 14;
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0] norm;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] stable;

  assign norm = {(KEY_ACTIVE_LOW ? ~key_raw : key_raw), sw_raw};

  // Idle level after normalization is 0 for every bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= norm;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt       <= '0;
        stable[i] <= 1'b0;
      end else if (sync2[i] == stable[i]) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt       <= '0;
        stable[i] <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Strobe rises in the same cycle the bus bit rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_input_bus <= '0;
      key_press    <= '0;
    end else begin
      io_input_bus <= stable;
      key_press    <= stable[13:10] & ~io_input_bus[13:10];
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner with a short debounce.
// Expected bus/strobe values are queued per cycle as stimulus is driven.
module tb_io_input_conditioner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_raw = 4'hF;
  logic [9:0]  sw_raw = '0;
  logic [13:0] io_input_bus;
  logic [3:0]  key_press;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(16),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_raw(key_raw),
    .sw_raw(sw_raw),
    .io_input_bus(io_input_bus),
    .key_press(key_press)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          tid;
    logic [13:0] bus;
    logic [3:0]  press;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   tid = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(int at, logic [13:0] b, logic [3:0] p);
    exp_t e;
    e.cyc = at;
    e.tid = tid;
    e.bus = b;
    e.press = p;
    sbq.push_back(e);
  endtask

  task automatic span(int from, int to, logic [13:0] b, logic [3:0] p);
    for (int c = from; c <= to; c++) push(c, b, p);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc != cyc) chk("stale", 32'(cyc), 32'(e.cyc));
      chk($sformatf("t%0d_bus@%0d", e.tid, e.cyc),
          32'(io_input_bus), 32'(e.bus));
      chk($sformatf("t%0d_press@%0d", e.tid, e.cyc),
          32'(key_press), 32'(e.press));
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int k;

  initial begin
    // 1: reset with idle pins, then stay idle
    tid = 1;
    #1;
    chk("rst_bus", 32'(io_input_bus), 32'h0);
    chk("rst_press", 32'(key_press), 32'h0);
    run(3);
    chk("rst_hold_bus", 32'(io_input_bus), 32'h0);
    reset = 1'b0;
    k = cyc;
    span(k + 1, k + 10, 14'h0000, 4'h0);
    run(10);

    // 2: switch 3 on, accepted exactly 6 edges after first sample
    tid = 2;
    k = cyc;
    sw_raw[3] = 1'b1;
    span(k + 1, k + 6, 14'h0000, 4'h0);
    span(k + 7, k + 10, 14'h0008, 4'h0);
    run(10);

    // 3: 3-cycle glitch on key 1 is rejected
    tid = 3;
    k = cyc;
    span(k + 1, k + 15, 14'h0008, 4'h0);
    key_raw[1] = 1'b0;
    run(3);
    key_raw[1] = 1'b1;
    run(12);

    // 4: key 2 press and release
    tid = 4;
    k = cyc;
    key_raw[2] = 1'b0;
    span(k + 1, k + 6, 14'h0008, 4'h0);
    push(k + 7, 14'h1008, 4'h4);
    span(k + 8, k + 20, 14'h1008, 4'h0);
    run(20);
    k = cyc;
    key_raw[2] = 1'b1;
    span(k + 1, k + 6, 14'h1008, 4'h0);
    span(k + 7, k + 20, 14'h0008, 4'h0);
    run(20);

    // 5: every pin changes in the same cycle
    tid = 5;
    k = cyc;
    sw_raw = 10'h3FF;
    key_raw = 4'h0;
    span(k + 1, k + 6, 14'h0008, 4'h0);
    push(k + 7, 14'h3FFF, 4'hF);
    span(k + 8, k + 12, 14'h3FFF, 4'h0);
    run(12);

    // 6: reset mid-debounce, then pins held through release
    tid = 6;
    k = cyc;
    sw_raw[0] = 1'b0;
    span(k + 1, k + 4, 14'h3FFF, 4'h0);
    run(4);
    reset = 1'b1;
    #1;
    chk("mid_rst_bus", 32'(io_input_bus), 32'h0);
    chk("mid_rst_press", 32'(key_press), 32'h0);
    k = cyc;
    span(k + 1, k + 2, 14'h0000, 4'h0);
    run(2);
    reset = 1'b0;
    k = cyc;
    span(k + 1, k + 6, 14'h0000, 4'h0);
    push(k + 7, 14'h3FFE, 4'hF);
    span(k + 8, k + 10, 14'h3FFE, 4'h0);
    run(10);

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
